// File: rtl/pg_src_arbiter.sv
// Round-robin arbiter feeding the packet-generator source port.
// One packet in flight; releases on pkt_done or busy timeout.
module pg_src_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      pg_src_valid,
    input  logic                      pg_src_ready,
    output logic [DATA_W-1:0]         pg_src_data,
    output logic [ID_W-1:0]           pg_src_id,
    input  logic                      pkt_done,
    output logic [ID_W-1:0]           done_id,
    output logic                      done_pulse,
    output logic                      timeout_err,
    input  logic                      err_clr,
    output logic [15:0]               grant_count
);

    localparam int IW1 = ID_W + 1;
    localparam int TW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] T_LAST =
        TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0] ID_MAX = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [15:0]         gc_q, gc_d;
    logic                dpulse_q, dpulse_d;
    logic [ID_W-1:0]     did_q, did_d;
    logic                err_q, err_d;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [DATA_W-1:0]   win_data;
    logic [IW1-1:0]      idx_w;

    // Pick the first requester at or after the round-robin pointer
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx_w     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_w = {1'b0, rr_q} + IW1'(k);
            if (idx_w >= IW1'(N_REQ)) begin
                idx_w = idx_w - IW1'(N_REQ);
            end
            if (!win_found && req_valid[idx_w[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx_w[ID_W-1:0];
            end
        end
    end

    // Route the winner's descriptor
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and register updates for the offer/busy cycle
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        id_d     = id_q;
        data_d   = data_q;
        timer_d  = timer_q;
        gc_d     = gc_q;
        dpulse_d = 1'b0;
        did_d    = did_q;
        err_d    = err_q & ~err_clr;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    id_d    = win_id;
                    data_d  = win_data;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (pg_src_ready) begin
                    gc_d    = gc_q + 16'd1;
                    rr_d    = (id_q == ID_MAX) ? '0 : id_q + 1'b1;
                    timer_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                if (pkt_done) begin
                    dpulse_d = 1'b1;
                    did_d    = id_q;
                    state_d  = IDLE;
                end else if (TO_EN && timer_q == T_LAST) begin
                    err_d    = 1'b1;
                    dpulse_d = 1'b1;
                    did_d    = id_q;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            id_q     <= '0;
            data_q   <= '0;
            timer_q  <= '0;
            gc_q     <= '0;
            dpulse_q <= 1'b0;
            did_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            data_q   <= data_d;
            timer_q  <= timer_d;
            gc_q     <= gc_d;
            dpulse_q <= dpulse_d;
            did_q    <= did_d;
            err_q    <= err_d;
        end
    end

    assign pg_src_valid = (state_q == OFFER);
    assign pg_src_data  = data_q;
    assign pg_src_id    = id_q;
    assign done_pulse   = dpulse_q;
    assign done_id      = did_q;
    assign timeout_err  = err_q;
    assign grant_count  = gc_q;

    // Ready goes back only to the requester being offered
    assign req_ready = (state_q == OFFER && pg_src_ready)
                     ? ({{(N_REQ-1){1'b0}}, 1'b1} << id_q)
                     : '0;

endmodule
